menu_ctl: RTL and testbench

Main-menu controller for the 16x16 text overlay. Debounces the three board buttons, moves the cursor between the "Single Player" line (text row 0) and the "Multi Player" line (text row 6), and confirms a selection to start the game. It drives the row index the text renderer highlights, and drives the mode and start pulse consumed by the game core. It returns to the menu when the game core signals game over.

---
 rtl/menu_ctl_pkg.sv | 20 ++
 rtl/menu_ctl_btn_debounce.sv | 60 ++++++
 rtl/menu_ctl.sv | 125 ++++++++++++
 tb/tb_menu_ctl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/menu_ctl_pkg.sv
// Shared definitions for the main-menu controller and the text renderer:
// FSM state encoding, default menu rows and the cursor-to-row mapping.
package menu_ctl_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        CONFIRM = 2'd1,
        GAME    = 2'd2
    } menu_state_e;

    localparam logic [3:0] ROW_SINGLE_DEF = 4'h0;
    localparam logic [3:0] ROW_MULTI_DEF  = 4'h6;

    function automatic logic [3:0] cursor_row(input logic       cur,
                                              input logic [3:0] row_single,
                                              input logic [3:0] row_multi);
        return cur ? row_multi : row_single;
    endfunction

endpackage

// File: rtl/menu_ctl_btn_debounce.sv
// Per-button conditioning: 2-FF synchronizer, counter debounce and a
// one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
    input  logic pclk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The accepting sample is the last of DEBOUNCE_CYCLES differing ones, so
    // the counter stops at its terminal value and cannot wrap.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/menu_ctl.sv
// Main-menu FSM with registered outputs for the text overlay and game core.
// Build option: define MENU_WRAP_EN to make the cursor wrap instead of saturate.
module menu_ctl
    import menu_ctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65000,
    parameter logic [3:0]  ROW_SINGLE      = ROW_SINGLE_DEF,
    parameter logic [3:0]  ROW_MULTI       = ROW_MULTI_DEF
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       game_over,
    output logic [3:0] highlight_row,
    output logic       menu_active,
    output logic       game_mode,
    output logic       game_start
);

    logic        up_ev;
    logic        down_ev;
    logic        sel_ev;
    logic        up_lvl;
    logic        down_lvl;
    logic        sel_lvl;
    logic        unused_lvl;
    logic        up_target;
    logic        down_target;

    menu_state_e state_q, state_d;
    logic        cur_q, cur_d;
    logic        mode_q, mode_d;
    logic [3:0]  row_q, row_d;
    logic        active_q, active_d;
    logic        start_q, start_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .pclk(pclk), .rst(rst), .btn_i(btn_up), .level_o(up_lvl), .press_o(up_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .pclk(pclk), .rst(rst), .btn_i(btn_down), .level_o(down_lvl), .press_o(down_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .pclk(pclk), .rst(rst), .btn_i(btn_sel), .level_o(sel_lvl), .press_o(sel_ev)
    );

    assign unused_lvl = up_lvl ^ down_lvl;

`ifdef MENU_WRAP_EN
    assign up_target   = ~cur_q;
    assign down_target = ~cur_q;
`else
    assign up_target   = 1'b0;
    assign down_target = 1'b1;
`endif

    // Outputs are derived from next-state values so they register together
    // with the state; game_mode is captured only when CONFIRM hands off.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        mode_d  = mode_q;
        start_d = 1'b0;
        case (state_q)
            MENU: begin
                if (sel_ev) begin
                    state_d = CONFIRM;
                end else if (up_ev && !down_ev) begin
                    cur_d = up_target;
                end else if (down_ev && !up_ev) begin
                    cur_d = down_target;
                end else begin
                    state_d = MENU;
                end
            end
            CONFIRM: begin
                if (!sel_lvl) begin
                    state_d = GAME;
                    mode_d  = cur_q;
                    start_d = 1'b1;
                end else begin
                    state_d = CONFIRM;
                end
            end
            GAME: begin
                if (game_over) begin
                    state_d = MENU;
                end else begin
                    state_d = GAME;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase
        row_d    = cursor_row(cur_d, ROW_SINGLE, ROW_MULTI);
        active_d = (state_d != GAME);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= MENU;
            cur_q    <= 1'b0;
            mode_q   <= 1'b0;
            row_q    <= ROW_SINGLE;
            active_q <= 1'b1;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            mode_q   <= mode_d;
            row_q    <= row_d;
            active_q <= active_d;
            start_q  <= start_d;
        end
    end

    assign highlight_row = row_q;
    assign menu_active   = active_q;
    assign game_mode     = mode_q;
    assign game_start    = start_q;

endmodule

// File: tb/tb_menu_ctl.sv
// Table-driven bench for menu_ctl with DEBOUNCE_CYCLES=4; expectations follow
// the MENU_WRAP_EN setting of the build.
module tb_menu_ctl;

    logic       pclk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic       game_over;
    logic [3:0] highlight_row;
    logic       menu_active;
    logic       game_mode;
    logic       game_start;

    int n_chk;
    int n_pass;
    int start_cnt;

`ifdef MENU_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [3:0] ROW_2ND_DOWN = WRAP ? 4'd0 : 4'd6;
    localparam logic [3:0] ROW_1ST_UP   = WRAP ? 4'd6 : 4'd0;

    typedef struct {
        logic       up;
        logic       dn;
        logic       sl;
        logic       go;
        int         ncyc;
        logic [3:0] row;
        logic       act;
        logic       mode;
        logic       start;
        int         starts;
    } seg_t;

    seg_t segs[$];

    menu_ctl #(.DEBOUNCE_CYCLES(4)) dut (
        .pclk(pclk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .btn_sel(btn_sel), .game_over(game_over), .highlight_row(highlight_row),
        .menu_active(menu_active), .game_mode(game_mode), .game_start(game_start)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic seg_t mk(input logic up, input logic dn, input logic sl,
                                input logic go, input int ncyc, input logic [3:0] row,
                                input logic act, input logic mode, input logic start,
                                input int starts);
        seg_t s;
        s.up = up; s.dn = dn; s.sl = sl; s.go = go; s.ncyc = ncyc;
        s.row = row; s.act = act; s.mode = mode; s.start = start; s.starts = starts;
        return s;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Advance n rising edges, counting game_start pulses just after each edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge pclk);
            #1;
            if (game_start === 1'b1) start_cnt++;
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] row, input logic act,
                            input logic mode, input logic start);
        if (act) chk({tag, " row"}, int'(highlight_row), int'(row));
        chk({tag, " active"}, int'(menu_active), int'(act));
        chk({tag, " mode"}, int'(game_mode), int'(mode));
        chk({tag, " start"}, int'(game_start), int'(start));
    endtask

    initial begin
        n_chk = 0; n_pass = 0; start_cnt = 0;
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; game_over = 1'b0;

        // idle, glitch rejection, first down press latency
        segs.push_back(mk(0,0,0,0,20, 4'd0,1,0,0,0));
        segs.push_back(mk(0,1,0,0, 3, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 1, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,1,0,0, 3, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 1, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,1,0,0, 3, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,1,0,0, 6, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,1,0,0, 1, 4'd6,1,0,0,-1));
        segs.push_back(mk(0,1,0,0, 3, 4'd6,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd6,1,0,0,-1));
        // saturation or wrap at both ends, simultaneous up+down, stray game_over
        segs.push_back(mk(0,1,0,0, 8, ROW_2ND_DOWN,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, ROW_2ND_DOWN,1,0,0,-1));
        segs.push_back(mk(1,0,0,0, 8, ROW_1ST_UP,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, ROW_1ST_UP,1,0,0,-1));
        segs.push_back(mk(1,0,0,0, 8, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd0,1,0,0,-1));
        segs.push_back(mk(1,1,0,0, 8, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,1, 1, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 2, 4'd0,1,0,0,-1));
        segs.push_back(mk(0,1,0,0, 8, 4'd6,1,0,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd6,1,0,0,-1));
        // select held, released, game start
        segs.push_back(mk(0,0,1,0,10, 4'd6,1,0,0,0));
        segs.push_back(mk(0,0,0,0, 6, 4'd6,1,0,0,0));
        segs.push_back(mk(0,0,0,0, 1, 4'd6,0,1,1,1));
        segs.push_back(mk(0,0,0,0, 1, 4'd6,0,1,0,1));
        // buttons ignored in GAME, then game_over
        segs.push_back(mk(1,0,0,0, 8, 4'd6,0,1,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd6,0,1,0,-1));
        segs.push_back(mk(0,1,0,0, 8, 4'd6,0,1,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd6,0,1,0,-1));
        segs.push_back(mk(0,0,1,0, 8, 4'd6,0,1,0,-1));
        segs.push_back(mk(0,0,0,0, 8, 4'd6,0,1,0,1));
        segs.push_back(mk(0,0,0,1, 1, 4'd6,1,1,0,-1));
        segs.push_back(mk(0,0,0,0, 4, 4'd6,1,1,0,-1));
        // re-enter GAME
        segs.push_back(mk(0,0,1,0, 8, 4'd6,1,1,0,-1));
        segs.push_back(mk(0,0,0,0, 6, 4'd6,1,1,0,-1));
        segs.push_back(mk(0,0,0,0, 1, 4'd6,0,1,1,2));
        segs.push_back(mk(0,0,0,0, 2, 4'd6,0,1,0,-1));

        repeat (2) @(negedge pclk);
        chk_outs("in reset", 4'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < segs.size(); i++) begin
            btn_up = segs[i].up; btn_down = segs[i].dn;
            btn_sel = segs[i].sl; game_over = segs[i].go;
            run(segs[i].ncyc);
            @(negedge pclk);
            chk_outs($sformatf("seg%0d", i), segs[i].row, segs[i].act,
                     segs[i].mode, segs[i].start);
            if (segs[i].starts >= 0)
                chk($sformatf("seg%0d start count", i), start_cnt, segs[i].starts);
        end

        // asynchronous reset in GAME with a down press part-way through debounce
        btn_down = 1'b1; btn_up = 1'b0; btn_sel = 1'b0; game_over = 1'b0;
        run(5);
        #1 rst = 1'b1;
        #1 chk_outs("async reset", 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge pclk);
        rst = 1'b0; btn_down = 1'b0;
        run(10);
        @(negedge pclk);
        chk_outs("after reset", 4'd0, 1'b1, 1'b0, 1'b0);
        chk("after reset start count", start_cnt, 2);
        btn_down = 1'b1;
        run(8);
        @(negedge pclk);
        chk_outs("post-reset press", 4'd6, 1'b1, 1'b0, 1'b0);
        btn_down = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
